mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit sequencer for the five-stage pipeline; sits in the E stage.
- Accepts MDU-class instructions, models their multi-cycle latency, and owns the HI/LO registers.
- Drives o_start/o_busy, which the hazard unit uses to stall D-stage md/mt/mf instructions.
- Cancels launch when an interrupt/exception request is asserted in the same cycle, so no architectural state changes for a flushed instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range ≥1).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_op  input  4  E-stage MDU operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- i_a  input  32  rs operand, already forwarded.
- i_b  input  32  rt operand, already forwarded.
- i_req  input  1  interrupt/exception request this cycle; blocks all state-changing ops.
- o_start  output  1  combinational: a mult/div launches this cycle.
- o_busy  output  1  registered: an operation is in flight.
- o_rdata  output  32  combinational: HI for mfhi, LO for mflo, else 0.
- o_hi  output  32  architectural HI (debug/observe).
- o_lo  output  32  architectural LO (debug/observe).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counter 0, HI=LO=0, pending regs 0, o_busy=0. o_start=0 while in reset.
- States: IDLE, RUN.
- Launch condition, evaluated in IDLE only: i_op in {1..4} and i_req=0 gives o_start=1 in that cycle (cycle t). At the edge ending t:
  - compute result into pending HI/LO;
  - counter ← MULT_CYCLES or DIV_CYCLES;
  - state ← RUN.
- In RUN:
  - o_busy=1.
  - Each edge decrements counter.
  - The edge where counter==1 commits pending→HI/LO and returns to IDLE.
  - Net effect: o_busy high exactly cycles t+1..t+N; new HI/LO visible from cycle t+N+1.
- mthi/mtlo in IDLE with i_req=0: HI (resp. LO) ← i_a at the edge ending that cycle; o_busy stays 0.
- mfhi/mflo: purely combinational read of current HI/LO. Not blocked by i_req, since a read has no side effect.
- Any i_op≠0 while in RUN: ignored, with no state change and o_start=0. The hazard unit guarantees this does not occur; verify with an assertion.
- i_req=1 in a launch cycle: o_start=0, nothing latched, state stays IDLE.
- i_req during RUN: no effect; the in-flight operation completes.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundaries:
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): the operation still occupies DIV_CYCLES, but HI/LO are left unchanged at commit.
- Operand capture: i_a/i_b are sampled only in the launch cycle; later changes have no effect.
- Reset asserted mid-RUN: immediately IDLE, o_busy=0, HI/LO=0, pending result discarded.
- Back-to-back: in the cycle after commit the block is IDLE, and a new launch is accepted with o_start=1 that cycle.

Test Plan:
- Signed multiply: mult a=0xFFFFFFFD (-3), b=5 → o_start=1 for 1 cycle; o_busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned divide: divu a=17, b=5 → o_busy=1 for exactly 10 cycles; then LO=3, HI=2.
- Signed divide: div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero, after mthi 0x1234 and mtlo 0x5678 → HI/LO unchanged; o_busy still 10 cycles.
- Overflow divide: div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- i_req blocking: mult with i_req=1 → o_start=0, o_busy stays 0, HI/LO unchanged. mtlo 0xAA with i_req=1 → LO unchanged. Retry with i_req=0 → op takes effect.
- Move/read: mthi 0xDEADBEEF → next cycle, mfhi gives o_rdata=0xDEADBEEF; mflo gives 0; i_op=0 gives 0.
- Reset mid-op: launch div, deassert i_rst_n at busy cycle 4 → o_busy=0 and HI=LO=0 immediately, asynchronously. After release, a new multu 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE after 5 busy cycles.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// MDU request/response bundle between the E-stage pipeline and the MDU sequencer.
// The master side drives the operation and operands; the slave side returns status and HI/LO.
interface mdu_ctrl_if;
  logic [3:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_req;
  logic        o_start;
  logic        o_busy;
  logic [31:0] o_rdata;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  modport master (
    output i_op, i_a, i_b, i_req,
    input  o_start, o_busy, o_rdata, o_hi, o_lo
  );

  modport slave (
    input  i_op, i_a, i_b, i_req,
    output o_start, o_busy, o_rdata, o_hi, o_lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage. The result is computed when the op
// launches and is held in pending registers. HI/LO only change at the end of the
// modelled latency, so o_busy reflects the real multi-cycle timing to the hazard unit.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic              wr_pend_q, wr_pend_d;
  logic              is_mul, is_div, launch;
  logic [63:0]       res;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Signed divide via magnitudes. Returns {remainder, quotient}. The quotient is
  // truncated toward zero and the remainder takes the dividend's sign.
  // 0x80000000 / -1 wraps to 0x80000000 with no trap. A zero divisor is masked to
  // avoid an undefined result; that result is never committed.
  function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    if (ub == 32'd0) ub = 32'd1;
    uq = ua / ub;
    ur = ua % ub;
    q  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    r  = a[31] ? (~ur + 32'd1) : ur;
    return {r, q};
  endfunction

  // Unsigned divide. Returns {remainder, quotient}. A zero divisor is masked as in div_s.
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ub;
    ub = (b == 32'd0) ? 32'd1 : b;
    return {a % ub, a / ub};
  endfunction

  // Decode the launch condition. Reset forces it low, so o_start is 0 during reset.
  always_comb begin
    is_mul = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
    is_div = (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
    launch = i_rst_n && (state_q == IDLE) && (is_mul || is_div) && !bus.i_req;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. The counter reaching 1 marks the final busy cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN:  if (cnt_q <= CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. o_busy depends only on registered state.
  always_comb begin
    bus.o_start = launch;
    bus.o_busy  = (state_q == RUN);
    bus.o_hi    = hi_q;
    bus.o_lo    = lo_q;
    unique case (bus.i_op)
      OP_MFHI: bus.o_rdata = hi_q;
      OP_MFLO: bus.o_rdata = lo_q;
      default: bus.o_rdata = 32'd0;
    endcase
  end

  // Datapath next values: capture the result at launch, count down while running, commit on the last cycle.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    wr_pend_d = wr_pend_q;
    unique case (bus.i_op)
      OP_MULT:  res = mul_s(bus.i_a, bus.i_b);
      OP_MULTU: res = mul_u(bus.i_a, bus.i_b);
      OP_DIV:   res = div_s(bus.i_a, bus.i_b);
      OP_DIVU:  res = div_u(bus.i_a, bus.i_b);
      default:  res = 64'd0;
    endcase
    if (launch) begin
      {hi_pend_d, lo_pend_d} = res;
      wr_pend_d = is_mul || (bus.i_b != 32'd0);
      cnt_d     = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (state_q == IDLE) begin
      if (!bus.i_req && bus.i_op == OP_MTHI) hi_d = bus.i_a;
      if (!bus.i_req && bus.i_op == OP_MTLO) lo_d = bus.i_a;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q <= CNT_W'(1) && wr_pend_q) begin
        hi_d = hi_pend_q;
        lo_d = lo_pend_q;
      end
    end
  end

  // Datapath registers. Reset discards any in-flight result and clears HI/LO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // The hazard unit stalls MDU ops while one is in flight; any op seen here would be dropped.
  a_no_op_in_run: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == RUN) |-> (bus.i_op == 4'd0));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, i_req blocking, moves/reads, and async reset.
module tb_mdu_ctrl;
  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7,
                         OP_MFLO = 4'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    bus.i_op  = op;
    bus.i_a   = a;
    bus.i_b   = b;
    bus.i_req = req;
  endtask

  // Launch in the current cycle, scramble operands while busy, count busy cycles, then check HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(op, a, b, 1'b0);
    #1;
    chk({tag, "_start"}, 32'(bus.o_start), 32'd1);
    step();
    drive(OP_NONE, $urandom, $urandom, 1'b0);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 64) begin
      n++;
      step();
      bus.i_a = $urandom;
      bus.i_b = $urandom;
    end
    chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
    chk({tag, "_hi"}, bus.o_hi, exp_hi);
    chk({tag, "_lo"}, bus.o_lo, exp_lo);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v, input logic req);
    drive(op, v, 32'd0, req);
    step();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: a pending mult on the inputs must not raise o_start.
    drive(OP_MULT, 32'd3, 32'd3, 1'b0);
    #12;
    chk("rst_start", 32'(bus.o_start), 32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_hi",    bus.o_hi,         32'd0);
    chk("rst_lo",    bus.o_lo,         32'd0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Arithmetic, issued back to back.
    run_op("mult",  OP_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("divu",  OP_DIVU, 32'd17, 32'd5, 10, 32'd2, 32'd3);
    run_op("div",   OP_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // Divide by zero leaves HI/LO untouched.
    mt(OP_MTHI, 32'h1234, 1'b0);
    chk("mthi_busy", 32'(bus.o_busy), 32'd0);
    mt(OP_MTLO, 32'h5678, 1'b0);
    run_op("div0",  OP_DIV,  32'd9, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("divov", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    // i_req blocks launch and moves.
    drive(OP_MULT, 32'd7, 32'd9, 1'b1);
    #1;
    chk("req_start", 32'(bus.o_start), 32'd0);
    step();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    chk("req_busy", 32'(bus.o_busy), 32'd0);
    step();
    chk("req_busy2", 32'(bus.o_busy), 32'd0);
    chk("req_hi", bus.o_hi, 32'd0);
    chk("req_lo", bus.o_lo, 32'h80000000);
    mt(OP_MTLO, 32'hAA, 1'b1);
    chk("req_mtlo", bus.o_lo, 32'h80000000);
    mt(OP_MTLO, 32'hAA, 1'b0);
    chk("mtlo", bus.o_lo, 32'hAA);
    run_op("mult_retry", OP_MULT, 32'd7, 32'd9, 5, 32'd0, 32'h3F);

    // Moves and combinational reads.
    mt(OP_MTLO, 32'd0, 1'b0);
    mt(OP_MTHI, 32'hDEADBEEF, 1'b0);
    drive(OP_MFHI, 32'd0, 32'd0, 1'b0);
    #1 chk("mfhi", bus.o_rdata, 32'hDEADBEEF);
    drive(OP_MFHI, 32'd0, 32'd0, 1'b1);
    #1 chk("mfhi_req", bus.o_rdata, 32'hDEADBEEF);
    drive(OP_MFLO, 32'd0, 32'd0, 1'b0);
    #1 chk("mflo", bus.o_rdata, 32'd0);
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    #1 chk("rd_none", bus.o_rdata, 32'd0);
    drive(4'd12, 32'd1, 32'd1, 1'b0);
    #1 chk("rd_bad", bus.o_rdata, 32'd0);
    chk("start_bad", 32'(bus.o_start), 32'd0);
    step();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    chk("bad_busy", 32'(bus.o_busy), 32'd0);
    chk("bad_hi", bus.o_hi, 32'hDEADBEEF);

    // Asynchronous reset in busy cycle 4 of a div.
    drive(OP_DIV, 32'd100, 32'd7, 1'b0);
    #1 chk("rdiv_start", 32'(bus.o_start), 32'd1);
    step();
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    step();
    step();
    step();
    chk("rdiv_busy4", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(bus.o_busy), 32'd0);
    chk("rmid_hi",   bus.o_hi, 32'd0);
    chk("rmid_lo",   bus.o_lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'd1, 32'hFFFFFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
